// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer placing two requesters (A: core, B: debug/DMA) in front of
// a single-port data memory; one transaction at a time, registered read data, one-cycle ACK.
module dmem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_i,
    input  logic              a_we_i,
    input  logic [ADDR_W-1:0] a_addr_i,
    input  logic [DATA_W-1:0] a_wdata_i,
    output logic [DATA_W-1:0] a_rdata_o,
    output logic              a_ack_o,
    input  logic              b_req_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_addr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic [DATA_W-1:0] b_rdata_o,
    output logic              b_ack_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i,
    output logic              busy_o
);

    // state  | meaning
    // IDLE   | waiting for a request, arbitrates on entry
    // ACCESS | memory driven with latched txn, waits out RD_LAT
    // RESP   | owner's ACK pulse, requests ignored
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam int CNT_W = 2;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                owner_q, owner_d;      // 0 = A, 1 = B
    logic                last_q, last_d;        // last granted port, same encoding
    logic                first_q, first_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic                grant_a, grant_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            first_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            first_q   <= first_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        owner_d   = owner_q;
        last_d    = last_q;
        first_d   = first_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        grant_a   = 1'b0;
        grant_b   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // On a tie, the port that did not win last time goes first
                grant_a = a_req_i && (!b_req_i || last_q);
                grant_b = b_req_i && !grant_a;
                if (grant_a || grant_b) begin
                    owner_d = grant_b;
                    last_d  = grant_b;
                    addr_d  = grant_b ? b_addr_i  : a_addr_i;
                    we_d    = grant_b ? b_we_i    : a_we_i;
                    wdata_d = grant_b ? b_wdata_i : a_wdata_i;
                    cnt_d   = CNT_W'(RD_LAT);
                    first_d = 1'b1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                first_d = 1'b0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) begin
                        if (owner_q) b_rdata_d = mem_dout_i;
                        else         a_rdata_d = mem_dout_i;
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write strobe is decoded from state so reset removes it without waiting for a clock
    assign mem_we_o   = (state_q == S_ACCESS) && first_q && we_q;
    assign mem_addr_o = addr_q;
    assign mem_din_o  = wdata_q;
    assign a_rdata_o  = a_rdata_q;
    assign b_rdata_o  = b_rdata_q;
    assign a_ack_o    = (state_q == S_RESP) && !owner_q;
    assign b_ack_o    = (state_q == S_RESP) && owner_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural memory/arbitration model feeds per-port
// expectation queues; a negedge monitor checks every ACK and the held read data.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_init;

    logic        a_req, a_we, b_req, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [63:0] a_wdata, b_wdata;
    logic [63:0] a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [63:0] mem_din, mem_dout;
    logic        busy;
    logic [63:0] mem_arr [32];

    logic        u2_a_req, u2_a_we, u2_b_req, u2_b_we;
    logic [4:0]  u2_a_addr, u2_b_addr;
    logic [63:0] u2_a_wdata, u2_b_wdata;
    logic [63:0] u2_a_rdata, u2_b_rdata;
    logic        u2_a_ack, u2_b_ack;
    logic [4:0]  u2_mem_addr;
    logic        u2_mem_we;
    logic [63:0] u2_mem_din, u2_mem_dout;
    logic        u2_busy;
    logic [63:0] u2_mem_arr [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(64), .RD_LAT(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rdata_o(a_rdata), .a_ack_o(a_ack),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rdata_o(b_rdata), .b_ack_o(b_ack),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_din_o(mem_din),
        .mem_dout_i(mem_dout), .busy_o(busy)
    );

    dmem_arbiter #(.ADDR_W(5), .DATA_W(64), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .a_req_i(u2_a_req), .a_we_i(u2_a_we), .a_addr_i(u2_a_addr), .a_wdata_i(u2_a_wdata),
        .a_rdata_o(u2_a_rdata), .a_ack_o(u2_a_ack),
        .b_req_i(u2_b_req), .b_we_i(u2_b_we), .b_addr_i(u2_b_addr), .b_wdata_i(u2_b_wdata),
        .b_rdata_o(u2_b_rdata), .b_ack_o(u2_b_ack),
        .mem_addr_o(u2_mem_addr), .mem_we_o(u2_mem_we), .mem_din_o(u2_mem_din),
        .mem_dout_i(u2_mem_dout), .busy_o(u2_busy)
    );

    // Single-port memories with combinational read
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) begin
                mem_arr[i]    <= 64'd0;
                u2_mem_arr[i] <= 64'd0;
            end
        end else begin
            if (mem_we)    mem_arr[mem_addr]       <= mem_din;
            if (u2_mem_we) u2_mem_arr[u2_mem_addr] <= u2_mem_din;
        end
    end
    assign mem_dout    = mem_arr[mem_addr];
    assign u2_mem_dout = u2_mem_arr[u2_mem_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: memory contents, each port's read-data register, round-robin pointer
    logic [63:0] model_mem [32];
    logic [63:0] model_rd [2];
    bit          model_last;
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];

    task automatic model_reset();
        model_rd[0] = 64'd0;
        model_rd[1] = 64'd0;
        model_last  = 1'b1;
    endtask

    task automatic model_apply(input bit port, input bit we, input logic [4:0] addr,
                               input logic [63:0] wd);
        if (we) model_mem[addr] = wd;
        else    model_rd[port] = model_mem[addr];
        if (port) exp_b_q.push_back(model_rd[1]);
        else      exp_a_q.push_back(model_rd[0]);
        model_last = port;
    endtask

    logic [63:0] hold_a = 64'd0;
    logic [63:0] hold_b = 64'd0;

    always @(negedge clk) begin
        logic [63:0] e;
        chk("ack_exclusive", {63'd0, a_ack & b_ack}, 64'd0);
        if (!rst_n) begin
            hold_a = 64'd0;
            hold_b = 64'd0;
        end
        if (a_ack) begin
            if (exp_a_q.size() == 0) chk("a_unexpected_ack", 64'd1, 64'd0);
            else begin
                e = exp_a_q.pop_front();
                chk("a_rdata_at_ack", a_rdata, e);
                hold_a = e;
            end
        end else chk("a_rdata_held", a_rdata, hold_a);
        if (b_ack) begin
            if (exp_b_q.size() == 0) chk("b_unexpected_ack", 64'd1, 64'd0);
            else begin
                e = exp_b_q.pop_front();
                chk("b_rdata_at_ack", b_rdata, e);
                hold_b = e;
            end
        end else chk("b_rdata_held", b_rdata, hold_b);
    end

    // One arbitration round: each selected port issues one txn and holds it until its ACK
    task automatic run_round(input bit da, input bit db, input bit wa, input bit wb,
                             input logic [4:0] aa, input logic [4:0] ab,
                             input logic [63:0] dA, input logic [63:0] dB,
                             output int la, output int lb, output int wecnt);
        int  n;
        bit  first_b;
        first_b = db && (!da || !model_last);
        if (first_b) begin
            model_apply(1'b1, wb, ab, dB);
            if (da) model_apply(1'b0, wa, aa, dA);
        end else begin
            if (da) model_apply(1'b0, wa, aa, dA);
            if (db) model_apply(1'b1, wb, ab, dB);
        end
        la = -1; lb = -1; wecnt = 0; n = 0;
        @(posedge clk); #1;
        a_req = da; a_we = wa; a_addr = aa; a_wdata = dA;
        b_req = db; b_we = wb; b_addr = ab; b_wdata = dB;
        @(posedge clk);
        while ((a_req || b_req) && n < 30) begin
            @(negedge clk);
            n++;
            if (mem_we) wecnt++;
            if (a_ack) begin la = n; a_req = 1'b0; end
            if (b_ack) begin lb = n; b_req = 1'b0; end
        end
        chk("round_timeout", {62'd0, a_req, b_req}, 64'd0);
        if (da) chk("a_latency", 64'(la), (db && first_b) ? 64'd5 : 64'd2);
        if (db) chk("b_latency", 64'(lb), (da && !first_b) ? 64'd5 : 64'd2);
    endtask

    task automatic u2_txn(input bit we, input logic [4:0] addr, input logic [63:0] wd,
                          output int lat, output int wecnt);
        int n;
        lat = -1; wecnt = 0; n = 0;
        @(posedge clk); #1;
        u2_b_req = 1'b1; u2_b_we = we; u2_b_addr = addr; u2_b_wdata = wd;
        @(posedge clk);
        while (u2_b_req && n < 30) begin
            @(negedge clk);
            n++;
            if (u2_mem_we) wecnt++;
            if (u2_b_ack) begin
                lat = n;
                u2_b_req = 1'b0;
            end else if (n <= 3) begin
                chk("u2_mem_addr_hold", 64'(u2_mem_addr), 64'(addr));
                chk("u2_busy", {63'd0, u2_busy}, 64'd1);
            end
        end
        chk("u2_latency", 64'(lat), 64'd4);
    endtask

    initial begin
        int la, lb, wc, n, k, prev, r;
        bit ord [12];
        bit wa, wb;
        logic [63:0] dA, dB;

        rst_n = 1'b0; mem_init = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        u2_a_req = 0; u2_a_we = 0; u2_a_addr = 0; u2_a_wdata = 0;
        u2_b_req = 0; u2_b_we = 0; u2_b_addr = 0; u2_b_wdata = 0;
        for (int i = 0; i < 32; i++) model_mem[i] = 64'd0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_we",   {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_din",  mem_din, 64'd0);
        chk("rst_busy",     {63'd0, busy}, 64'd0);
        chk("rst_acks",     {62'd0, a_ack, b_ack}, 64'd0);
        chk("rst_rdata_a",  a_rdata, 64'd0);
        chk("rst_rdata_b",  b_rdata, 64'd0);
        mem_init = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie straight after reset: A first, B three cycles later sees A's write
        run_round(1, 1, 1, 0, 5'd11, 5'd11, 64'd300, 64'd0, la, lb, wc);
        chk("tie_b_after_a", 64'(lb - la), 64'd3);

        // Single A write then read: one write strobe cycle, latency 2
        run_round(1, 0, 1, 0, 5'd11, 5'd0, 64'd150, 64'd0, la, lb, wc);
        chk("a_write_we_pulses", 64'(wc), 64'd1);
        run_round(1, 0, 0, 0, 5'd11, 5'd0, 64'd0, 64'd0, la, lb, wc);
        chk("a_read_we_pulses", 64'(wc), 64'd0);

        // Full-width B write/read at the top address
        run_round(0, 1, 0, 1, 5'd0, 5'd31, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, la, lb, wc);
        run_round(0, 1, 0, 0, 5'd0, 5'd31, 64'd0, 64'd0, la, lb, wc);

        // Continuous requests from both ports: strict alternation every 3 cycles
        run_round(1, 1, 1, 1, 5'd1, 5'd2, 64'd7, 64'd9, la, lb, wc);
        for (int i = 0; i < 12; i++) begin
            ord[i] = !model_last;
            model_apply(ord[i], 1'b0, ord[i] ? 5'd2 : 5'd1, 64'd0);
        end
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 5'd1;
        b_req = 1; b_we = 0; b_addr = 5'd2;
        n = 0; k = 0; prev = 0;
        while (k < 12 && n < 100) begin
            @(negedge clk);
            n++;
            if (a_ack || b_ack) begin
                chk("alt_order", {63'd0, b_ack}, {63'd0, ord[k]});
                if (k > 0) chk("ack_spacing", 64'(n - prev), 64'd3);
                prev = n;
                k++;
                if (k == 12) begin a_req = 0; b_req = 0; end
            end
        end
        chk("cont_done", 64'(k), 64'd12);
        a_req = 0; b_req = 0;

        // Randomized rounds against the model
        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(1, 3);
            wa = $urandom_range(0, 1);
            wb = $urandom_range(0, 1);
            dA = {$urandom, $urandom};
            dB = {$urandom, $urandom};
            run_round(r[0], r[1], wa, wb, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      dA, dB, la, lb, wc);
        end

        // Reset in the first ACCESS cycle of a write: strobe drops before any write edge
        run_round(1, 0, 1, 0, 5'd4, 5'd0, 64'd5, 64'd0, la, lb, wc);
        @(posedge clk); #1;
        a_req = 1; a_we = 1; a_addr = 5'd4; a_wdata = 64'd77;
        @(posedge clk); #2;
        chk("pre_rst_mem_we", {63'd0, mem_we}, 64'd1);
        rst_n = 1'b0;
        a_req = 0;
        #1;
        chk("midrst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("midrst_busy",   {63'd0, busy}, 64'd0);
        model_reset();
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_ack", {62'd0, a_ack, b_ack}, 64'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("postrst_no_ack", {62'd0, a_ack, b_ack}, 64'd0);
        end
        run_round(1, 0, 0, 0, 5'd4, 5'd0, 64'd0, 64'd0, la, lb, wc);
        chk("postrst_mem4", mem_arr[4], 64'd5);

        // RD_LAT=2 instance: B write 42 @3, then read back
        u2_txn(1'b1, 5'd3, 64'd42, la, wc);
        chk("u2_write_we_pulses", 64'(wc), 64'd1);
        u2_txn(1'b0, 5'd3, 64'd0, la, wc);
        chk("u2_b_rdata", u2_b_rdata, 64'd42);
        chk("u2_a_ack_idle", {63'd0, u2_a_ack}, 64'd0);

        repeat (3) @(negedge clk);
        chk("exp_queues_drained", 64'(exp_a_q.size() + exp_b_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port 32 x 64-bit data memory.
- Port A serves the core load/store path; port B serves a debug/DMA master.
- Grants one transaction at a time with a round-robin policy.
- Drives the memory address, write-enable and write-data, then returns registered read data with a one-cycle ACK pulse.

Parameters:
- ADDR_W, 5, memory word-address width.
- DATA_W, 64, data width.
- RD_LAT, 0, extra memory read-latency cycles (legal 0..3). 0 means the memory read is combinational from ADDR.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- A_REQ  in  1  port A request.
- A_WE  in  1  port A write (1) / read (0).
- A_ADDR  in  ADDR_W  port A address.
- A_WDATA  in  DATA_W  port A write data.
- A_RDATA  out  DATA_W  port A read data; registered, valid while A_ACK=1, held until the next A read completes.
- A_ACK  out  1  port A completion pulse, one cycle.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_RDATA, B_ACK: same meaning for port B.
- MEM_ADDR  out  ADDR_W  to memory ADDR.
- MEM_WE  out  1  to memory WE.
- MEM_DIN  out  DATA_W  to memory D_in.
- MEM_DOUT  in  DATA_W  from memory D_out.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, latency counter=0.
  - latched addr/we/wdata/owner=0.
  - A_RDATA=B_RDATA=0, A_ACK=B_ACK=0.
  - last_grant=B, so A wins the first tie.
  - MEM_WE=0 immediately, not waiting for CLK.
  - MEM_ADDR=0, MEM_DIN=0.
- State machine:
  - IDLE:
    - If exactly one REQ is high, grant it.
    - If both are high, grant the port that is not last_grant.
    - On grant, latch that port's ADDR/WE/WDATA and owner, update last_grant, set counter=RD_LAT, go ACCESS.
    - If no REQ, stay in IDLE.
  - ACCESS:
    - MEM_ADDR = latched addr and MEM_DIN = latched wdata throughout.
    - MEM_WE = latched we, in the first ACCESS cycle only, giving exactly one memory write per transaction.
    - While counter≠0, decrement and stay.
    - When counter=0:
      - Read: capture MEM_DOUT into the owner's RDATA.
      - Write: the owner's RDATA is unchanged.
      - Set the owner's ACK and go RESP.
  - RESP: the owner's ACK=1 for this single cycle; go IDLE. No REQ is sampled in RESP.
- Timing and throughput:
  - A REQ sampled at edge k gives ACK high during cycle k+2+RD_LAT.
  - Back-to-back throughput is one transaction per 3+RD_LAT cycles.
- Requester protocol:
  - Hold REQ, WE, ADDR and WDATA stable until ACK.
  - In the ACK cycle the requester may drop REQ or present a new request.
  - A REQ still high in the IDLE cycle after RESP is treated as a new request.
- Fairness:
  - With both ports requesting continuously, grants strictly alternate.
  - Worst-case wait is one foreign transaction.
- Outside ACCESS: MEM_WE=0 and MEM_ADDR/MEM_DIN hold their last latched values.
- ACK exclusivity: never both ACKs high at once; ACK is never high outside RESP.
- Request changes: a REQ drop during ACCESS does not abort; the transaction completes and ACKs.
- Reset mid-transaction:
  - The in-flight transaction is discarded and no ACK is issued.
  - A write whose MEM_WE edge has already occurred stays in memory. No further write occurs.
- Address range: no address checking; the full 2^ADDR_W range is passed through.

Test Plan:
- A write 150 to addr 5'b01011, then A read addr 5'b01011.
  - The write ACK arrives 2 cycles after the REQ is sampled, with MEM_WE high for exactly 1 cycle.
  - The read ACK delivers A_RDATA=150.
- A write 300 @11 and B read @11 raised in the same cycle after reset.
  - A is granted first.
  - B_ACK arrives 3 cycles after A_ACK with B_RDATA=300.
  - A_ACK and B_ACK are never high together.
- A and B both hold REQ for 12 transactions (A reads @1, B reads @2, memory preloaded with 7 and 9).
  - Grants alternate A,B,A,B…
  - Each ACK is 3 cycles apart.
  - A_RDATA=7 and B_RDATA=9 every time.
- RD_LAT=2 build, B read @3 holding 42.
  - B_ACK arrives 4 cycles after the REQ is sampled with B_RDATA=42.
  - MEM_ADDR=3 is held for all 3 ACCESS cycles.
- RST_N pulsed low in the first ACCESS cycle of an A write of 77 @4 (prior content 5).
  - MEM_WE drops immediately, BUSY=0, and no ACK is issued.
  - After reset the next A grant proceeds normally.
  - A read @4 returns 77 if the write edge preceded reset, else 5; check against the exact edge.
- A single B write 64'hFFFF_FFFF_FFFF_FFFF @31 followed by a read.
  - Full-width data round-trips.
  - A_RDATA is unchanged throughout.
